// File: rtl/load_store_unit.sv
// Load/store unit: turns RISC-V byte/half/word accesses into word-indexed memory cycles.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned accesses; otherwise low address bits are forced aligned.
module load_store_unit #(
  parameter int MEM_WORDS = 1024,
  parameter int XLEN      = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_is_store,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_fault,
  output logic            mem_read_en,
  output logic            mem_write_en,
  output logic [XLEN-1:0] mem_address,
  output logic [XLEN-1:0] mem_write_data,
  input  logic [XLEN-1:0] mem_read_data
);

  // state   | meaning
  // S_IDLE  | waiting for a request, req_ready high
  // S_LOAD  | memory read, extended data registered
  // S_ST_W  | full-word write
  // S_RMW_RD| read old word, register merged word
  // S_RMW_WR| write merged word
  // S_RESP  | response held until resp_ready
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ST_W, S_RMW_RD, S_RMW_WR, S_RESP} state_t;

  state_t          state, state_nxt;
  logic            is_store_q;
  logic [2:0]      funct3_q;
  logic [XLEN-1:0] addr_q, wdata_q, merge_q, rdata_q;
  logic            fault_q;

  logic            legal, misalign, out_of_range, req_fault;
  logic [XLEN-1:0] addr_eff;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [XLEN-1:0] load_val, merge_val;

  assign legal = req_is_store ? (req_funct3 inside {3'b000, 3'b001, 3'b010})
                              : (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
  assign out_of_range = {2'b00, req_addr[XLEN-1:2]} >= XLEN'(MEM_WORDS);

`ifdef LSU_MISALIGN_TRAP_EN
  assign addr_eff = req_addr;
  assign misalign = ((req_funct3[1:0] == 2'b01) & req_addr[0]) |
                    ((req_funct3[1:0] == 2'b10) & (|req_addr[1:0]));
`else
  assign addr_eff = {req_addr[XLEN-1:2],
                     (req_funct3[1:0] == 2'b10) ? 1'b0 : req_addr[1],
                     (req_funct3[1:0] == 2'b00) ? req_addr[0] : 1'b0};
  assign misalign = 1'b0;
`endif

  assign req_fault = !legal || misalign || out_of_range;

  always_comb begin
    byte_sel  = 8'h00;
    half_sel  = addr_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];
    load_val  = '0;
    merge_val = mem_read_data;
    case (addr_q[1:0])
      2'b00: byte_sel = mem_read_data[7:0];
      2'b01: byte_sel = mem_read_data[15:8];
      2'b10: byte_sel = mem_read_data[23:16];
      default: byte_sel = mem_read_data[31:24];
    endcase
    case (funct3_q)
      3'b000: load_val = {{24{byte_sel[7]}}, byte_sel};
      3'b001: load_val = {{16{half_sel[15]}}, half_sel};
      3'b010: load_val = mem_read_data;
      3'b100: load_val = {24'h0, byte_sel};
      3'b101: load_val = {16'h0, half_sel};
      default: load_val = '0;
    endcase
    if (funct3_q[0]) merge_val[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    else             merge_val[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    mem_read_en    = 1'b0;
    mem_write_en   = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_fault)              state_nxt = S_RESP;
          else if (!req_is_store)     state_nxt = S_LOAD;
          else if (req_funct3[1])     state_nxt = S_ST_W;
          else                        state_nxt = S_RMW_RD;
        end
      end
      S_LOAD: begin
        mem_read_en = 1'b1;
        mem_address = {2'b00, addr_q[XLEN-1:2]};
        state_nxt   = S_RESP;
      end
      S_ST_W: begin
        mem_write_en   = 1'b1;
        mem_address    = {2'b00, addr_q[XLEN-1:2]};
        mem_write_data = wdata_q;
        state_nxt      = S_RESP;
      end
      S_RMW_RD: begin
        mem_read_en = 1'b1;
        mem_address = {2'b00, addr_q[XLEN-1:2]};
        state_nxt   = S_RMW_WR;
      end
      S_RMW_WR: begin
        mem_write_en   = 1'b1;
        mem_address    = {2'b00, addr_q[XLEN-1:2]};
        mem_write_data = merge_q;
        state_nxt      = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Request latch plus response registers; rdata stays zero for stores and faults.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      is_store_q <= 1'b0;
      funct3_q   <= 3'b000;
      addr_q     <= '0;
      wdata_q    <= '0;
      merge_q    <= '0;
      rdata_q    <= '0;
      fault_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          is_store_q <= req_is_store;
          funct3_q   <= req_funct3;
          addr_q     <= addr_eff;
          wdata_q    <= req_wdata;
          rdata_q    <= '0;
          fault_q    <= req_fault;
        end
        S_LOAD:   rdata_q <= load_val;
        S_RMW_RD: merge_q <= merge_val;
        S_RESP: if (resp_ready) begin
          rdata_q <= '0;
          fault_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign resp_rdata = rdata_q;
  assign resp_fault = fault_q;

  // is_store_q is kept for debug visibility of the latched request.
  logic unused_ok;
  assign unused_ok = is_store_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus random traffic against a byte-level memory model.
// Expected alignment behaviour follows LSU_MISALIGN_TRAP_EN when defined.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_is_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        resp_valid, resp_ready = 1'b0, resp_fault;
  logic [31:0] resp_rdata;
  logic        mem_read_en, mem_write_en;
  logic [31:0] mem_address, mem_write_data, mem_read_data;

  bit [31:0] mem     [0:1023];
  bit [31:0] ref_mem [0:1023];
  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_WORDS(1024), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_fault(resp_fault), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_address(mem_address), .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  assign mem_read_data = (mem_address < 32'd1024) ? mem[mem_address[9:0]] : 32'h0;
  always @(posedge clk)
    if (mem_write_en && mem_address < 32'd1024) mem[mem_address[9:0]] <= mem_write_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Reference: byte-addressed view of memory, sizes and extension from funct3.
  task automatic ref_txn(input bit st, input bit [2:0] f3, input bit [31:0] addr, input bit [31:0] wd,
                         output bit flt, output bit [31:0] rd, output int lat,
                         output int nrd, output int nwr, output bit [31:0] widx);
    longint unsigned a, v;
    int size, idx, sh;
    bit legal, mis;
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    a = addr;
    mis = (a % size) != 0;
`ifndef LSU_MISALIGN_TRAP_EN
    a = a - (a % size);
    mis = 1'b0;
`endif
    flt = !legal || mis || (a / 4 >= 1024);
    rd = 0; nrd = 0; nwr = 0; lat = 1;
    widx = 32'(a / 4);
    if (!flt && st) begin
      for (int k = 0; k < size; k++) begin
        idx = int'((a + k) / 4);
        sh  = 8 * int'((a + k) % 4);
        ref_mem[idx] = (ref_mem[idx] & ~(32'hFF << sh)) | (((wd >> (8 * k)) & 32'hFF) << sh);
      end
      lat = (size == 4) ? 2 : 3;
      nrd = (size == 4) ? 0 : 1;
      nwr = 1;
    end else if (!flt) begin
      v = 0;
      for (int k = 0; k < size; k++) begin
        idx = int'((a + k) / 4);
        sh  = 8 * int'((a + k) % 4);
        v = v | (longint'((ref_mem[idx] >> sh) & 32'hFF) << (8 * k));
      end
      if (!f3[2] && size < 4 && ((v >> (8 * size - 1)) & 1) == 1)
        v = v | (64'hFFFF_FFFF_FFFF_FFFF << (8 * size));
      rd = v[31:0];
      lat = 2;
      nrd = 1;
    end
  endtask

  task automatic run_txn(input bit st, input bit [2:0] f3, input bit [31:0] addr, input bit [31:0] wd,
                         input int hold, output bit [31:0] obs_rd);
    bit e_flt; bit [31:0] e_rd, e_widx, waddr;
    int e_lat, e_nrd, e_nwr, lat, rdc, wrc, n;
    bit got, both;
    ref_txn(st, f3, addr, wd, e_flt, e_rd, e_lat, e_nrd, e_nwr, e_widx);
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    got = 0; both = 0; rdc = 0; wrc = 0; lat = 0; waddr = '0;
    for (int j = 0; j < 10 && !got; j++) begin
      @(negedge clk);
      if (j == 0) req_valid = 1'b0;
      rdc += int'(mem_read_en);
      wrc += int'(mem_write_en);
      both |= mem_read_en & mem_write_en;
      if (mem_write_en) waddr = mem_address;
      if (resp_valid) begin got = 1; lat = j + 1; end
    end
    obs_rd = resp_rdata;
    chk("resp_latency", got ? 32'(lat) : 32'd99, 32'(e_lat));
    chk("resp_rdata", resp_rdata, e_rd);
    chk("resp_fault", {31'b0, resp_fault}, {31'b0, e_flt});
    chk("busy_ready", {31'b0, req_ready}, 32'd0);
    chk("read_cycles", 32'(rdc), 32'(e_nrd));
    chk("write_cycles", 32'(wrc), 32'(e_nwr));
    chk("enables_both", {31'b0, both}, 32'd0);
    if (e_nwr != 0) chk("write_index", waddr, e_widx);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", {31'b0, resp_valid}, 32'd1);
      chk("hold_rdata", resp_rdata, e_rd);
      chk("hold_fault", {31'b0, resp_fault}, {31'b0, e_flt});
      chk("hold_ready", {31'b0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("resp_drop", {31'b0, resp_valid}, 32'd0);
  endtask

  initial begin
    bit [31:0] r, addr;
    bit [2:0]  f3;
    #12;
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_fault", {31'b0, resp_fault}, 32'd0);
    chk("rst_mem_en", {30'b0, mem_read_en, mem_write_en}, 32'd0);
    chk("rst_mem_addr", mem_address, 32'd0);
    chk("rst_mem_wdata", mem_write_data, 32'd0);
    @(negedge clk); rst = 1'b1;

    run_txn(1, 3'b010, 32'h10, 32'hDEADBEEF, 0, r);
    run_txn(0, 3'b010, 32'h10, 32'h0, 0, r);
    chk("lw_after_sw", r, 32'hDEADBEEF);
    run_txn(1, 3'b000, 32'h11, 32'h55, 0, r);
    run_txn(0, 3'b010, 32'h10, 32'h0, 0, r);
    chk("lw_after_sb", r, 32'hDEAD55EF);
    run_txn(0, 3'b000, 32'h13, 32'h0, 0, r);
    chk("lb_13", r, 32'hFFFFFFDE);
    run_txn(0, 3'b100, 32'h13, 32'h0, 0, r);
    chk("lbu_13", r, 32'h000000DE);
    run_txn(0, 3'b001, 32'h12, 32'h0, 0, r);
    chk("lh_12", r, 32'hFFFFDEAD);
    run_txn(0, 3'b101, 32'h12, 32'h0, 0, r);
    chk("lhu_12", r, 32'h0000DEAD);
    run_txn(0, 3'b010, 32'h11, 32'h0, 0, r);
    run_txn(0, 3'b010, 32'h1000, 32'h0, 0, r);
    run_txn(0, 3'b011, 32'h20, 32'h0, 5, r);
    run_txn(1, 3'b001, 32'hFFE, 32'h1234ABCD, 2, r);
    run_txn(0, 3'b001, 32'hFFE, 32'h0, 0, r);

    // Reset during the read half of a byte store must leave the word untouched.
    begin
      bit wr_seen;
      @(negedge clk);
      req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b000;
      req_addr = 32'h20; req_wdata = 32'hAB;
      @(posedge clk);
      #2;
      chk("rmw_rd_active", {31'b0, mem_read_en}, 32'd1);
      rst = 1'b0;
      #1;
      req_valid = 1'b0;
      chk("midrst_en", {30'b0, mem_read_en, mem_write_en}, 32'd0);
      chk("midrst_addr", mem_address, 32'd0);
      chk("midrst_ready", {31'b0, req_ready}, 32'd1);
      chk("midrst_valid", {31'b0, resp_valid}, 32'd0);
      wr_seen = 0;
      repeat (3) begin @(negedge clk); wr_seen |= mem_write_en; end
      rst = 1'b1;
      repeat (3) begin @(negedge clk); wr_seen |= mem_write_en; end
      chk("midrst_no_write", {31'b0, wr_seen}, 32'd0);
      chk("midrst_word8", mem[8], ref_mem[8]);
    end

    for (int t = 0; t < 200; t++) begin
      case ($urandom_range(0, 9))
        0: addr = 32'h1000 + $urandom_range(0, 255);
        1: addr = 32'hFFC + $urandom_range(0, 3);
        2: addr = $urandom;
        default: addr = $urandom_range(0, 127);
      endcase
      f3 = 3'($urandom_range(0, 7));
      run_txn(1'($urandom_range(0, 1)), f3, addr, $urandom, $urandom_range(0, 2), r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
